shift_add_mult_seq: RTL and testbench

//   Sequential unsigned N x N multiplier controller. Sequences one shared N-bit adder

---
 rtl/shift_add_mult_seq.sv | 93 +++++++++
 tb/tb_shift_add_mult_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned N x N shift-and-add multiplier with valid/ready handshakes on both sides.
// Latency: N+1 edges from the accept edge to out_valid; one operation in flight at a time.
// Backpressure: product and out_valid are held in DONE until out_ready; in_ready stays low until IDLE.
module shift_add_mult_seq #(
    parameter int N = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N-1:0]   product_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     acc_hi_q, acc_hi_d;
    logic [N-1:0]     acc_lo_q, acc_lo_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N:0]       sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        // Carry-out lands in sum[N] and is shifted into the top of acc_hi.
        sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    mcand_d  = a_i;
                    acc_lo_d = b_i;
                    acc_hi_d = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_d = sum[N:1];
                acc_lo_d = {sum[0], acc_lo_q[N-1:1]};
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign out_valid_o = (state_q == S_DONE) && !rst_i;
    assign busy_o      = (state_q != S_IDLE) && !rst_i;
    assign product_o   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Bench for shift_add_mult_seq: directed cases followed by randomized traffic scored against a*b.
module tb_shift_add_mult_seq;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    always #5 clk = ~clk;

    shift_add_mult_seq #(.N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a pair, wait for acceptance, then scramble a/b to show they are not resampled.
    task automatic launch(input logic [N-1:0] xa, input logic [N-1:0] xb);
        int w = 0;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        start_cyc = cyc;
        tick();
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
    endtask

    task automatic wait_result(input logic [2*N-1:0] exp, input string tag);
        int w = 0;
        while (!out_valid && w < 60) begin
            tick();
            w++;
        end
        chk({tag, "_lat"}, 32'(cyc - start_cyc), 32'(N + 1));
        chk({tag, "_prod"}, 32'(product), 32'(exp));
    endtask

    task automatic op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                      input logic [2*N-1:0] exp, input string tag);
        out_ready = 1'b1;
        launch(xa, xb);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(exp, tag);
        tick();
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin : main
        logic [2*N-1:0] q[$];
        int             ops;
        int             acc_cyc;
        logic           lat_done;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        tick();
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_product", 32'(product),   32'd0);
        chk("rst_inready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("idle_inready", 32'(in_ready), 32'd1);

        // Basic, all-ones carry case, and zero operands
        op(8'd13,  8'd11,  16'd143,   "t1");
        op(8'd255, 8'd255, 16'hFE01,  "t2");
        op(8'd0,   8'd200, 16'd0,     "t3a");
        op(8'd200, 8'd0,   16'd0,     "t3b");

        // Backpressure with a pending pair held by the producer
        out_ready = 1'b0;
        launch(8'd13, 8'd11);
        wait_result(16'd143, "t4");
        in_valid = 1'b1;
        a        = 8'd3;
        b        = 8'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_prod",  32'(product),   32'd143);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        launch(8'd3, 8'd4);
        wait_result(16'd12, "t4b");
        out_ready = 1'b1;
        tick();

        // Reset in the middle of an operation
        launch(8'd100, 8'd50);
        tick();
        tick();
        tick();
        chk("t5_busy_run", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy_in_rst",    32'(busy),     32'd0);
        chk("t5_inready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_busy",    32'(busy),      32'd0);
        chk("t5_valid",   32'(out_valid), 32'd0);
        chk("t5_product", 32'(product),   32'd0);
        chk("t5_inready", 32'(in_ready),  32'd1);
        op(8'd7, 8'd9, 16'd63, "t5b");

        // Randomized traffic: every accepted pair must come back exactly once as a*b
        ops      = 0;
        acc_cyc  = 0;
        lat_done = 1'b1;
        while (ops < 1000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = N'($urandom);
            b         = N'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            if (out_valid && !lat_done) begin
                chk("rand_lat", 32'(cyc - acc_cyc), 32'(N + 1));
                lat_done = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_dup", 32'd1, 32'd0);
                end else begin
                    chk("rand_prod", 32'(product), 32'(q.pop_front()));
                end
                ops++;
            end
            if (in_valid && in_ready) begin
                q.push_back((2*N)'(a) * (2*N)'(b));
                acc_cyc  = cyc;
                lat_done = 1'b0;
            end
            tick();
        end
        chk("rand_ops",      32'(ops),      32'd1000);
        chk("rand_leftover", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
